// File: rtl/mnist_pixel_rx.sv
// Serial 1-bit pixel receiver: packs rows into IMG_W-bit words and double-buffers
// whole frames in two banks that the inference core reads by row and releases.
module mnist_pixel_rx #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ROW_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in,
  input  logic              valid_in,
  output logic              in_ready,
  output logic              frame_valid,
  output logic              frame_bank,
  input  logic [ROW_AW-1:0] rd_row,
  output logic [IMG_W-1:0]  rd_data,
  input  logic              frame_done,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              overflow
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_t;

  bank_state_t       state [2];
  logic [COL_W-1:0]  col;
  logic [ROW_AW-1:0] row;
  logic              wr_bank;
  logic              rd_bank;
  logic [IMG_W-1:0]  shift;
  logic [IMG_W-1:0]  mem [2][IMG_H];

  logic              accept;
  logic              col_last;
  logic              row_last;
  logic              release_bank;
  logic              rd_in_range;
  logic [IMG_W-1:0]  row_word;

  assign in_ready     = (state[wr_bank] == EMPTY);
  assign frame_valid  = (state[rd_bank] == FULL);
  assign frame_bank   = rd_bank;
  assign accept       = valid_in && in_ready;
  assign col_last     = (col == COL_W'(IMG_W - 1));
  assign row_last     = (row == ROW_AW'(IMG_H - 1));
  assign release_bank = frame_done && frame_valid;
  assign rd_in_range  = ({1'b0, rd_row} < (ROW_AW + 1)'(IMG_H));
  assign row_word     = {shift[IMG_W-2:0], data_in};

  // Release and completion always hit different banks (the write bank is never FULL),
  // so both updates may land in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      state[0]  <= EMPTY;
      state[1]  <= EMPTY;
      shift     <= '0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (valid_in && !in_ready) begin
        overflow <= 1'b1;
      end
      if (accept) begin
        shift <= row_word;
        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row            <= '0;
            state[wr_bank] <= FULL;
            wr_bank        <= ~wr_bank;
            frame_cnt      <= frame_cnt + CNT_W'(1);
          end else begin
            row <= row + ROW_AW'(1);
          end
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if (release_bank) begin
        state[rd_bank] <= EMPTY;
        rd_bank        <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept && col_last) begin
      mem[wr_bank][row] <= row_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (frame_valid && rd_in_range) begin
      rd_data <= mem[rd_bank][rd_row];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_mnist_pixel_rx.sv
// Directed bench for mnist_pixel_rx: frame packing, ping-pong banking, drops,
// mid-frame reset and the back-to-back release/complete corner case.
module tb_mnist_pixel_rx;

  localparam int W = 28;
  localparam int H = 28;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_in;
  logic        valid_in;
  logic        in_ready;
  logic        frame_valid;
  logic        frame_bank;
  logic [4:0]  rd_row;
  logic [27:0] rd_data;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  // 0 ones, 1 diagonal, 2 A, 3 B, 4 dropped, 5 random, 6 F, 7 G
  logic [27:0] img [8][H];

  typedef struct {
    logic [4:0]  row;
    logic [27:0] exp;
  } rd_vec_t;
  rd_vec_t vecs [36];

  mnist_pixel_rx dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .in_ready   (in_ready),
    .frame_valid(frame_valid),
    .frame_bank (frame_bank),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    valid_in = 1'b0;
    data_in = 1'b0;
    frame_done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Sends pixels [first,last) of image k in raster order, optionally with idle gaps.
  task automatic applyStimulus(input int k, input int first, input int last, input bit gaps);
    for (int p = first; p < last; p++) begin
      if (gaps) begin
        for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++) begin
          valid_in = 1'b0;
          tick();
        end
      end
      valid_in = 1'b1;
      data_in = img[k][p / W][W - 1 - (p % W)];
      tick();
    end
    valid_in = 1'b0;
    data_in = 1'b0;
  endtask

  task automatic checkRows(input string name, input int k);
    for (int r = 0; r < H; r++) begin
      rd_row = 5'(r);
      tick();
      checkOutput(name, 64'(rd_data), 64'(img[k][r]));
    end
  endtask

  task automatic pulseDone();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    data_in = 1'b0;
    frame_done = 1'b0;
    rd_row = '0;

    for (int r = 0; r < H; r++) begin
      img[0][r] = 28'hFFFFFFF;
      img[1][r] = 28'h1 << (27 - r);
      img[2][r] = 28'hA5A5A5A ^ 28'(r);
      img[3][r] = 28'h5A5A5A5 + 28'(r * 3);
      img[4][r] = 28'hFFFFFFF;
      img[5][r] = 28'($urandom);
      img[6][r] = 28'($urandom);
      img[7][r] = 28'($urandom);
    end
    for (int i = 0; i < 32; i++) begin
      vecs[i].row = 5'(i);
      vecs[i].exp = (i < H) ? (28'h1 << (27 - i)) : 28'h0;
    end
    vecs[32].row = 5'd27; vecs[32].exp = 28'h0000001;
    vecs[33].row = 5'd0;  vecs[33].exp = 28'h8000000;
    vecs[34].row = 5'd30; vecs[34].exp = 28'h0000000;
    vecs[35].row = 5'd13; vecs[35].exp = 28'h0004000;

    // Reset state and an ignored release
    doReset();
    checkOutput("rst_frame_valid", 64'(frame_valid), 64'd0);
    checkOutput("rst_frame_bank", 64'(frame_bank), 64'd0);
    checkOutput("rst_rd_data", 64'(rd_data), 64'd0);
    checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    pulseDone();
    checkOutput("idle_done_bank", 64'(frame_bank), 64'd0);
    checkOutput("idle_done_ready", 64'(in_ready), 64'd1);

    // T1 full-ones frame
    applyStimulus(0, 0, NPIX - 1, 1'b0);
    checkOutput("t1_valid_early", 64'(frame_valid), 64'd0);
    applyStimulus(0, NPIX - 1, NPIX, 1'b0);
    checkOutput("t1_valid", 64'(frame_valid), 64'd1);
    checkOutput("t1_bank", 64'(frame_bank), 64'd0);
    checkOutput("t1_cnt", 64'(frame_cnt), 64'd1);
    checkOutput("t1_ready", 64'(in_ready), 64'd1);
    checkRows("t1_row", 0);
    rd_row = 5'd28;
    tick();
    checkOutput("t1_row28", 64'(rd_data), 64'd0);
    pulseDone();
    checkOutput("t1_done_valid", 64'(frame_valid), 64'd0);
    checkOutput("t1_done_bank", 64'(frame_bank), 64'd1);
    rd_row = 5'd0;
    tick();
    checkOutput("t1_noframe_rd", 64'(rd_data), 64'd0);

    // T2 diagonal frame into bank 1, table-driven reads
    applyStimulus(1, 0, NPIX, 1'b0);
    checkOutput("t2_valid", 64'(frame_valid), 64'd1);
    checkOutput("t2_bank", 64'(frame_bank), 64'd1);
    checkOutput("t2_cnt", 64'(frame_cnt), 64'd2);
    for (int i = 0; i < 36; i++) begin
      rd_row = vecs[i].row;
      tick();
      checkOutput($sformatf("t2_vec%0d", i), 64'(rd_data), 64'(vecs[i].exp));
    end
    pulseDone();

    // T3 three frames, third dropped
    doReset();
    applyStimulus(2, 0, NPIX, 1'b0);
    applyStimulus(3, 0, NPIX, 1'b0);
    checkOutput("t3_ready_low", 64'(in_ready), 64'd0);
    checkOutput("t3_ovf_before", 64'(overflow), 64'd0);
    applyStimulus(4, 0, NPIX, 1'b0);
    checkOutput("t3_overflow", 64'(overflow), 64'd1);
    checkOutput("t3_cnt", 64'(frame_cnt), 64'd2);
    checkOutput("t3_bank0", 64'(frame_bank), 64'd0);
    checkRows("t3_rowsA", 2);
    pulseDone();
    checkOutput("t3_bank1", 64'(frame_bank), 64'd1);
    checkOutput("t3_ready_high", 64'(in_ready), 64'd1);
    checkOutput("t3_valid_b", 64'(frame_valid), 64'd1);
    checkRows("t3_rowsB", 3);
    checkOutput("t3_ovf_sticky", 64'(overflow), 64'd1);

    // T4 random image with random valid gaps
    doReset();
    applyStimulus(5, 0, NPIX, 1'b1);
    checkOutput("t4_valid", 64'(frame_valid), 64'd1);
    checkOutput("t4_cnt", 64'(frame_cnt), 64'd1);
    checkOutput("t4_overflow", 64'(overflow), 64'd0);
    checkRows("t4_row", 5);

    // T5 reset after 400 pixels, then full frame F
    doReset();
    applyStimulus(0, 0, 400, 1'b0);
    doReset();
    applyStimulus(6, 0, NPIX, 1'b0);
    checkOutput("t5_cnt", 64'(frame_cnt), 64'd1);
    checkOutput("t5_bank", 64'(frame_bank), 64'd0);
    checkRows("t5_row", 6);

    // T6 release bank 0 in the cycle bank 1 completes
    applyStimulus(7, 0, NPIX - 1, 1'b0);
    checkOutput("t6_valid_pre", 64'(frame_valid), 64'd1);
    valid_in = 1'b1;
    data_in = img[7][H - 1][0];
    frame_done = 1'b1;
    tick();
    valid_in = 1'b0;
    frame_done = 1'b0;
    checkOutput("t6_valid", 64'(frame_valid), 64'd1);
    checkOutput("t6_bank", 64'(frame_bank), 64'd1);
    checkOutput("t6_ready", 64'(in_ready), 64'd1);
    checkOutput("t6_cnt", 64'(frame_cnt), 64'd2);
    checkOutput("t6_overflow", 64'(overflow), 64'd0);
    checkRows("t6_row", 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
